// File: rtl/ctrl_alu_sched.sv
// Issue scheduler for the control ALU: round-robin two-lane arbiter, S1/S2 registers, mispredict recovery FSM.
// Optional macro CTRL_ALU_SCHED_STATS_EN adds saturating execute / mispredict counters.
module ctrl_alu_sched #(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 32,
  parameter int IMM_W        = 16,
  parameter int OPC_W        = 8,
  parameter int TAG_W        = 5,
  parameter int FLAGS_W      = 8,
  parameter int FLUSH_CYCLES = 2,
  localparam int PKT_W = 2*DATA_W + IMM_W + OPC_W + 2*PC_W + 1 + TAG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [PKT_W-1:0]   req0_pkt_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [PKT_W-1:0]   req1_pkt_i,
  output logic [DATA_W-1:0]  alu_data1_o,
  output logic [DATA_W-1:0]  alu_data2_o,
  output logic [IMM_W-1:0]   alu_immd_o,
  output logic [OPC_W-1:0]   alu_opcode_o,
  output logic [PC_W-1:0]    alu_pc_o,
  output logic [PC_W-1:0]    alu_pred_target_o,
  output logic               alu_pred_dir_o,
  input  logic [PC_W-1:0]    alu_result_i,
  input  logic [PC_W-1:0]    alu_nextpc_i,
  input  logic               alu_direction_i,
  input  logic [FLAGS_W-1:0] alu_flags_i,
  output logic               res_valid_o,
  output logic [PC_W-1:0]    res_result_o,
  output logic [PC_W-1:0]    res_nextpc_o,
  output logic               res_direction_o,
  output logic [FLAGS_W-1:0] res_flags_o,
  output logic [TAG_W-1:0]   res_tag_o,
  output logic               redirect_valid_o,
  output logic [PC_W-1:0]    redirect_pc_o,
  output logic [TAG_W-1:0]   redirect_tag_o,
  output logic               busy_o
`ifdef CTRL_ALU_SCHED_STATS_EN
  , output logic [15:0]      stat_exec_o,
  output logic [15:0]        stat_mispred_o
`endif
);

  localparam int PT_LSB  = TAG_W + 1;
  localparam int PC_LSB  = PT_LSB + PC_W;
  localparam int OPC_LSB = PC_LSB + PC_W;
  localparam int IMM_LSB = OPC_LSB + OPC_W;
  localparam int D2_LSB  = IMM_LSB + IMM_W;
  localparam int D1_LSB  = D2_LSB + DATA_W;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_REDIRECT = 2'd1, ST_FLUSH = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [3:0]         flush_cnt_q, flush_cnt_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [PKT_W-1:0]   s1_pkt_q, s1_pkt_d;
  logic               res_valid_q, res_valid_d;
  logic [PC_W-1:0]    res_result_q, res_result_d;
  logic [PC_W-1:0]    res_nextpc_q, res_nextpc_d;
  logic               res_dir_q, res_dir_d;
  logic [FLAGS_W-1:0] res_flags_q, res_flags_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic [PC_W-1:0]    redir_pc_q, redir_pc_d;
  logic [TAG_W-1:0]   redir_tag_q, redir_tag_d;

  logic               run, gnt_lane, hs, mispred, younger, keep;
  logic [PKT_W-1:0]   in_pkt;
  logic [TAG_W-1:0]   s1_tag, tag_diff;

  assign run      = (state_q == ST_RUN);
  assign gnt_lane = (req0_valid_i ^ req1_valid_i) ? req1_valid_i : rr_ptr_q;
  assign req0_ready_o = run & ~gnt_lane;
  assign req1_ready_o = run & gnt_lane;
  assign hs       = gnt_lane ? (req1_ready_o & req1_valid_i) : (req0_ready_o & req0_valid_i);
  assign in_pkt   = gnt_lane ? req1_pkt_i : req0_pkt_i;
  assign s1_tag   = s1_pkt_q[TAG_W-1:0];
  assign mispred  = s1_valid_q & alu_flags_i[0];

  // Younger than the mispredicting branch: modular distance in [1, half-range - 1].
  assign tag_diff = in_pkt[TAG_W-1:0] - s1_tag;
  assign younger  = (tag_diff != '0) & ~tag_diff[TAG_W-1];
  assign keep     = hs & ~(mispred & younger);

  // S1 payload is cleared when empty so every alu_* port reads 0.
  assign alu_data1_o       = s1_pkt_q[D1_LSB +: DATA_W];
  assign alu_data2_o       = s1_pkt_q[D2_LSB +: DATA_W];
  assign alu_immd_o        = s1_pkt_q[IMM_LSB +: IMM_W];
  assign alu_opcode_o      = s1_pkt_q[OPC_LSB +: OPC_W];
  assign alu_pc_o          = s1_pkt_q[PC_LSB +: PC_W];
  assign alu_pred_target_o = s1_pkt_q[PT_LSB +: PC_W];
  assign alu_pred_dir_o    = s1_pkt_q[TAG_W];

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (mispred) begin
      state_d = ST_REDIRECT;
    end else begin
      case (state_q)
        ST_REDIRECT: begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 4'(FLUSH_CYCLES - 1);
        end
        ST_FLUSH: begin
          if (flush_cnt_q == 4'd0) state_d = ST_RUN;
          else flush_cnt_d = flush_cnt_q - 4'd1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    s1_valid_d   = keep;
    s1_pkt_d     = keep ? in_pkt : '0;
    rr_ptr_d     = hs ? ~gnt_lane : rr_ptr_q;
    res_valid_d  = s1_valid_q;
    res_result_d = res_result_q;
    res_nextpc_d = res_nextpc_q;
    res_dir_d    = res_dir_q;
    res_flags_d  = res_flags_q;
    res_tag_d    = res_tag_q;
    redir_pc_d   = redir_pc_q;
    redir_tag_d  = redir_tag_q;
    if (s1_valid_q) begin
      res_result_d = alu_result_i;
      res_nextpc_d = alu_nextpc_i;
      res_dir_d    = alu_direction_i;
      res_flags_d  = alu_flags_i;
      res_tag_d    = s1_tag;
    end
    if (mispred) begin
      redir_pc_d  = alu_nextpc_i;
      redir_tag_d = s1_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      flush_cnt_q  <= '0;
      rr_ptr_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_pkt_q     <= '0;
      res_valid_q  <= 1'b0;
      res_result_q <= '0;
      res_nextpc_q <= '0;
      res_dir_q    <= 1'b0;
      res_flags_q  <= '0;
      res_tag_q    <= '0;
      redir_pc_q   <= '0;
      redir_tag_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_pkt_q     <= s1_pkt_d;
      res_valid_q  <= res_valid_d;
      res_result_q <= res_result_d;
      res_nextpc_q <= res_nextpc_d;
      res_dir_q    <= res_dir_d;
      res_flags_q  <= res_flags_d;
      res_tag_q    <= res_tag_d;
      redir_pc_q   <= redir_pc_d;
      redir_tag_q  <= redir_tag_d;
    end
  end

  assign res_valid_o      = res_valid_q;
  assign res_result_o     = res_result_q;
  assign res_nextpc_o     = res_nextpc_q;
  assign res_direction_o  = res_dir_q;
  assign res_flags_o      = res_flags_q;
  assign res_tag_o        = res_tag_q;
  assign redirect_valid_o = (state_q == ST_REDIRECT);
  assign redirect_pc_o    = redir_pc_q;
  assign redirect_tag_o   = redir_tag_q;
  assign busy_o           = s1_valid_q | ~run;

`ifdef CTRL_ALU_SCHED_STATS_EN
  logic [15:0] stat_exec_q, stat_exec_d, stat_mp_q, stat_mp_d;

  always_comb begin
    stat_exec_d = stat_exec_q;
    stat_mp_d   = stat_mp_q;
    if (s1_valid_q && stat_exec_q != 16'hFFFF) stat_exec_d = stat_exec_q + 16'd1;
    if (mispred && stat_mp_q != 16'hFFFF)      stat_mp_d   = stat_mp_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_exec_q <= '0;
      stat_mp_q   <= '0;
    end else begin
      stat_exec_q <= stat_exec_d;
      stat_mp_q   <= stat_mp_d;
    end
  end

  assign stat_exec_o    = stat_exec_q;
  assign stat_mispred_o = stat_mp_q;
`endif

endmodule

// File: tb/tb_ctrl_alu_sched.sv
// Bench for ctrl_alu_sched: directed test-plan steps then random traffic against a cycle-level reference model.
module tb_ctrl_alu_sched;
  localparam int FLUSH = 2;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [15:0] imm;
    logic [7:0]  opc;
    logic [31:0] pc;
    logic [31:0] pt;
    logic        pd;
    logic [4:0]  tag;
  } pkt_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  pkt_t        req0_pkt_i = '0, req1_pkt_i = '0;
  logic [31:0] alu_data1_o, alu_data2_o, alu_pc_o, alu_pred_target_o;
  logic [15:0] alu_immd_o;
  logic [7:0]  alu_opcode_o;
  logic        alu_pred_dir_o;
  logic [31:0] alu_result_i = '0, alu_nextpc_i = '0;
  logic        alu_direction_i = 1'b0;
  logic [7:0]  alu_flags_i = '0;
  logic        res_valid_o, res_direction_o, redirect_valid_o, busy_o;
  logic [31:0] res_result_o, res_nextpc_o, redirect_pc_o;
  logic [7:0]  res_flags_o;
  logic [4:0]  res_tag_o, redirect_tag_o;

  ctrl_alu_sched dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_pkt_i(req0_pkt_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_pkt_i(req1_pkt_i),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_immd_o(alu_immd_o),
    .alu_opcode_o(alu_opcode_o), .alu_pc_o(alu_pc_o), .alu_pred_target_o(alu_pred_target_o),
    .alu_pred_dir_o(alu_pred_dir_o), .alu_result_i(alu_result_i), .alu_nextpc_i(alu_nextpc_i),
    .alu_direction_i(alu_direction_i), .alu_flags_i(alu_flags_i),
    .res_valid_o(res_valid_o), .res_result_o(res_result_o), .res_nextpc_o(res_nextpc_o),
    .res_direction_o(res_direction_o), .res_flags_o(res_flags_o), .res_tag_o(res_tag_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_tag_o(redirect_tag_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference model state: blocked counts the cycles in which no lane may issue.
  int          m_ptr = 0, m_block = 0;
  bit          m_s1_v = 0, m_redir_v = 0, m_res_v = 0;
  pkt_t        m_s1 = '0;
  logic [31:0] m_redir_pc = '0, m_res_result = '0, m_res_nextpc = '0;
  logic [4:0]  m_redir_tag = '0, m_res_tag = '0;
  logic        m_res_dir = 1'b0;
  logic [7:0]  m_res_flags = '0;

  // The bench plays the ALU: d1[0] requests a mispredict and d2 is the resolved next PC.
  function automatic logic [72:0] alu_of(pkt_t p);
    return {p.d1 ^ p.d2, p.d2, p.pd ^ p.d1[0], 8'h24 | {7'b0, p.d1[0]}};
  endfunction

  function automatic pkt_t mk(logic [4:0] tag, logic [31:0] pc, bit mp, logic [31:0] tgt);
    pkt_t p;
    p.d1 = {16'hA5A5, 3'b0, tag, 7'b0, mp};
    p.d2 = tgt;
    p.imm = {11'h0, tag};
    p.opc = 8'h63;
    p.pc = pc;
    p.pt = pc + 32'h40;
    p.pd = tag[0];
    p.tag = tag;
    return p;
  endfunction

  function automatic pkt_t rnd_pkt();
    pkt_t p;
    p.d1 = $urandom;
    p.d1[0] = ($urandom_range(0, 5) == 0);
    p.d2 = $urandom;
    p.imm = 16'($urandom);
    p.opc = 8'($urandom);
    p.pc = $urandom;
    p.pt = $urandom;
    p.pd = 1'($urandom);
    p.tag = 5'($urandom);
    return p;
  endfunction

  task automatic chk(string name, logic [191:0] obs, logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against the model, advance the model, clock.
  task automatic step(bit rst, bit v0, pkt_t p0, bit v1, pkt_t p1);
    int gnt, d;
    bit run, hs, mp, yng;
    pkt_t inp;
    logic [72:0] a;
    reset = rst;
    req0_valid_i = v0; req0_pkt_i = p0;
    req1_valid_i = v1; req1_pkt_i = p1;
    a = m_s1_v ? alu_of(m_s1) : '0;
    {alu_result_i, alu_nextpc_i, alu_direction_i, alu_flags_i} = a;
    #1;
    run = (m_block == 0);
    gnt = (v0 && !v1) ? 0 : (v1 && !v0) ? 1 : m_ptr;
    chk("ready0", 192'(req0_ready_o), 192'(run && gnt == 0));
    chk("ready1", 192'(req1_ready_o), 192'(run && gnt == 1));
    chk("alu_bus", 192'({alu_data1_o, alu_data2_o, alu_immd_o, alu_opcode_o, alu_pc_o,
                         alu_pred_target_o, alu_pred_dir_o}),
        192'(m_s1_v ? m_s1[157:5] : 153'd0));
    chk("res_valid", 192'(res_valid_o), 192'(m_res_v));
    if (m_res_v)
      chk("res_data", 192'({res_result_o, res_nextpc_o, res_direction_o, res_flags_o, res_tag_o}),
          192'({m_res_result, m_res_nextpc, m_res_dir, m_res_flags, m_res_tag}));
    chk("redirect", 192'({redirect_valid_o, redirect_pc_o, redirect_tag_o}),
        192'({m_redir_v, m_redir_pc, m_redir_tag}));
    chk("busy", 192'(busy_o), 192'(m_s1_v || m_block > 0));
    if (rst) begin
      m_ptr = 0; m_block = 0; m_s1_v = 0; m_s1 = '0; m_redir_v = 0; m_res_v = 0;
      m_redir_pc = '0; m_redir_tag = '0;
      {m_res_result, m_res_nextpc, m_res_dir, m_res_flags, m_res_tag} = '0;
    end else begin
      hs = run && (gnt == 1 ? v1 : v0);
      inp = (gnt == 1) ? p1 : p0;
      mp = m_s1_v && m_s1.d1[0];
      d = (int'(inp.tag) - int'(m_s1.tag) + 32) % 32;
      yng = (d >= 1 && d <= 15);
      m_res_v = m_s1_v;
      if (m_s1_v) begin
        {m_res_result, m_res_nextpc, m_res_dir, m_res_flags} = a;
        m_res_tag = m_s1.tag;
      end
      m_redir_v = mp;
      if (mp) begin
        m_redir_pc = m_s1.d2;
        m_redir_tag = m_s1.tag;
        m_block = 1 + FLUSH;
      end else if (m_block > 0) begin
        m_block--;
      end
      m_s1_v = hs && !(mp && yng);
      m_s1 = m_s1_v ? inp : '0;
      if (hs) m_ptr = 1 - gnt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // Reset state, then lane0 BEQ pc 0x100 tag 3, no mispredict.
    idle(1);
    step(0, 1, mk(5'd3, 32'h100, 0, 32'h104), 0, '0);
    idle(3);
    // Both lanes busy for four cycles: alternating grants, back-to-back results.
    for (int i = 0; i < 4; i++)
      step(0, 1, mk(5'(8 + 2*i), 32'h200 + 32'(i*8), 0, 32'h0), 1, mk(5'(9 + 2*i), 32'h300, 0, 32'h0));
    idle(3);
    // Mispredict tag 5 -> 0x2000; tag 6 granted the same edge is younger and dropped.
    step(0, 1, mk(5'd5, 32'h400, 1, 32'h2000), 0, '0);
    step(0, 1, mk(5'd6, 32'h404, 0, 32'h0), 0, '0);
    idle(5);
    // Older tag 4 granted at the mispredict edge, itself mispredicts to 0x3000.
    step(0, 1, mk(5'd5, 32'h400, 1, 32'h2000), 0, '0);
    step(0, 0, '0, 1, mk(5'd4, 32'h3F0, 1, 32'h3000));
    idle(6);
    // Tag wrap around 30.
    step(0, 1, mk(5'd30, 32'h500, 1, 32'h5000), 0, '0);
    step(0, 1, mk(5'd1, 32'h504, 0, 32'h0), 0, '0);
    idle(5);
    step(0, 1, mk(5'd30, 32'h500, 1, 32'h5000), 0, '0);
    step(0, 1, mk(5'd20, 32'h4F0, 0, 32'h0), 0, '0);
    idle(5);
    // Reset while S1 holds a retained packet during recovery, and again mid-FLUSH.
    step(0, 1, mk(5'd5, 32'h600, 1, 32'h6000), 0, '0);
    step(0, 0, '0, 1, mk(5'd4, 32'h5F0, 0, 32'h0));
    step(1, 0, '0, 0, '0);
    idle(2);
    step(0, 1, mk(5'd7, 32'h700, 1, 32'h7000), 1, mk(5'd8, 32'h704, 0, 32'h0));
    idle(2);
    step(1, 1, rnd_pkt(), 1, rnd_pkt());
    idle(2);
    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) == 0, 1'($urandom), rnd_pkt(), 1'($urandom), rnd_pkt());
    idle(6);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
